oam_dma_ctrl: RTL

//  Sprite DMA engine behind CPU register $4014. A CPU write of page P halts the CPU and copies
//  256 bytes from $P00-$PFF into OAM. It does this by issuing 256 writes to PPU register 4
//  (OAMDATA) on the ppu_cs/ioreg_* bus, starting at the current OAMADDR. It sits between the
//  CPU bus arbiter and the PPU register block.

---
 rtl/oam_dma_if.sv | 26 ++
 rtl/oam_dma_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/oam_dma_if.sv
// Bus bundle between the sprite DMA controller and its surroundings (CPU arbiter,
// CPU memory read path, PPU register block).
interface oam_dma_if;
    logic        cpu_clock;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dataout;
    logic        cpu_wr;
    logic        dma_busy;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_datain;
    logic        ppu_cs;
    logic [2:0]  ioreg_addr;
    logic [7:0]  ioreg_datain;
    logic        ioreg_wr;

    modport master (
        input  cpu_clock, cpu_addr, cpu_dataout, cpu_wr, mem_datain,
        output dma_busy, mem_addr, mem_rd, ppu_cs, ioreg_addr, ioreg_datain, ioreg_wr
    );

    modport slave (
        output cpu_clock, cpu_addr, cpu_dataout, cpu_wr, mem_datain,
        input  dma_busy, mem_addr, mem_rd, ppu_cs, ioreg_addr, ioreg_datain, ioreg_wr
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine behind $4014: halts the CPU and copies one 256-byte page into OAM
// through 256 writes to PPU OAMDATA, one READ/WRITE CPU-cycle pair per byte.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int          XFER_LEN     = 256
) (
    input  logic       sysclk,
    input  logic       reset,
    oam_dma_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_CNT   = 8'(XFER_LEN - 1);
    localparam logic [2:0] OAMDATA_RG = 3'd4;

    state_t     state;
    logic [7:0] page;
    logic [7:0] cnt;
    logic       cpu_odd;
    logic       trigger_s;

    assign trigger_s = bus.cpu_wr && (bus.cpu_addr == DMA_REG_ADDR);

    // Transfer FSM; outputs are set together with the next state so they stay stable
    // for the whole CPU cycle that state occupies.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state            <= ST_IDLE;
            page             <= 8'h00;
            cnt              <= 8'h00;
            cpu_odd          <= 1'b0;
            bus.dma_busy     <= 1'b0;
            bus.mem_addr     <= 16'h0000;
            bus.mem_rd       <= 1'b0;
            bus.ppu_cs       <= 1'b0;
            bus.ioreg_addr   <= 3'd0;
            bus.ioreg_datain <= 8'h00;
            bus.ioreg_wr     <= 1'b0;
        end else if (bus.cpu_clock) begin
            cpu_odd <= ~cpu_odd;
            case (state)
                ST_IDLE: begin
                    if (trigger_s) begin
                        page         <= bus.cpu_dataout;
                        cnt          <= 8'h00;
                        state        <= ST_HALT;
                        bus.dma_busy <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    // Reads must land on even CPU cycles; burn one cycle if we are odd.
                    if (cpu_odd) begin
                        state <= ST_ALIGN;
                    end else begin
                        state        <= ST_READ;
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= {page, cnt};
                    end
                end
                ST_ALIGN: begin
                    state        <= ST_READ;
                    bus.mem_rd   <= 1'b1;
                    bus.mem_addr <= {page, cnt};
                end
                ST_READ: begin
                    state            <= ST_WRITE;
                    bus.ioreg_datain <= bus.mem_datain;
                    bus.mem_rd       <= 1'b0;
                    bus.ppu_cs       <= 1'b1;
                    bus.ioreg_wr     <= 1'b1;
                    bus.ioreg_addr   <= OAMDATA_RG;
                end
                ST_WRITE: begin
                    bus.ppu_cs     <= 1'b0;
                    bus.ioreg_wr   <= 1'b0;
                    bus.ioreg_addr <= 3'd0;
                    cnt            <= cnt + 8'd1;
                    if (cnt == LAST_CNT) begin
                        state        <= ST_IDLE;
                        bus.dma_busy <= 1'b0;
                    end else begin
                        state        <= ST_READ;
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= {page, cnt + 8'd1};
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    bus.dma_busy   <= 1'b0;
                    bus.mem_rd     <= 1'b0;
                    bus.ppu_cs     <= 1'b0;
                    bus.ioreg_wr   <= 1'b0;
                    bus.ioreg_addr <= 3'd0;
                end
            endcase
        end else begin
            state <= state;
        end
    end

endmodule
